// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads 16-bit instruction words as two byte reads
// (low byte first) over the 8-bit memory bus and offers each assembled word
// with its address to decode over a valid/ready handshake. Owns the PC and
// accepts absolute redirect targets from downstream.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [15:0] instr_word,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_en,
    input  logic [15:0] branch_target,
    input  logic        halt
);

    typedef enum logic [1:0] {
        ST_FETCH_LO = 2'd0,
        ST_FETCH_HI = 2'd1,
        ST_VALID    = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] pc_r;
    logic [15:0] start_pc_r;
    logic [7:0]  lo_r;
    logic [15:0] instr_word_r;
    logic [15:0] instr_pc_r;
    logic        rst_hold_r;
    logic        mem_rd_s;
    logic        lo_take_s;
    logic        hi_take_s;

    // A byte is only consumed when a request is actually outstanding this cycle.
    assign lo_take_s = (state_r == ST_FETCH_LO) && mem_rd_s && mem_ack;
    assign hi_take_s = (state_r == ST_FETCH_HI) && mem_rd_s && mem_ack;

    assign mem_rd      = mem_rd_s;
    assign mem_addr    = pc_r;
    assign instr_valid = (state_r == ST_VALID);
    assign instr_word  = instr_word_r;
    assign instr_pc    = instr_pc_r;

    // State register: reset always returns to the low-byte fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH_LO;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: a redirect overrides every state, otherwise advance on ack/accept.
    always_comb begin
        state_nxt_s = state_r;
        if (branch_en) begin
            state_nxt_s = ST_FETCH_LO;
        end else begin
            case (state_r)
                ST_FETCH_LO: begin
                    if (lo_take_s) begin
                        state_nxt_s = ST_FETCH_HI;
                    end else begin
                        state_nxt_s = ST_FETCH_LO;
                    end
                end
                ST_FETCH_HI: begin
                    if (hi_take_s) begin
                        state_nxt_s = ST_VALID;
                    end else begin
                        state_nxt_s = ST_FETCH_HI;
                    end
                end
                ST_VALID: begin
                    if (instr_ready) begin
                        state_nxt_s = ST_FETCH_LO;
                    end else begin
                        state_nxt_s = ST_VALID;
                    end
                end
                default: begin
                    state_nxt_s = ST_FETCH_LO;
                end
            endcase
        end
    end

    // Read request decode: halt only gates the low-byte read so a started word completes;
    // the cycle right after a reset edge issues no request.
    always_comb begin
        mem_rd_s = 1'b0;
        case (state_r)
            ST_FETCH_LO: mem_rd_s = !halt && !rst_hold_r;
            ST_FETCH_HI: mem_rd_s = !rst_hold_r;
            ST_VALID:    mem_rd_s = 1'b0;
            default:     mem_rd_s = 1'b0;
        endcase
    end

    // Remember that reset was sampled on the last edge so the bus stays idle for that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rst_hold_r <= 1'b1;
        end else begin
            rst_hold_r <= 1'b0;
        end
    end

    // Datapath: PC, partial low byte and the presented instruction word/address.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r         <= RESET_PC;
            start_pc_r   <= RESET_PC;
            lo_r         <= 8'h00;
            instr_word_r <= 16'h0000;
            instr_pc_r   <= RESET_PC;
        end else if (branch_en) begin
            // Any byte acked alongside the redirect is dropped.
            pc_r <= branch_target;
        end else if (lo_take_s) begin
            lo_r       <= mem_data;
            start_pc_r <= pc_r;
            pc_r       <= pc_r + 16'd1;
        end else if (hi_take_s) begin
            instr_word_r <= {mem_data, lo_r};
            instr_pc_r   <= start_pc_r;
            pc_r         <= pc_r + 16'd1;
        end else begin
            pc_r <= pc_r;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: byte-wide memory responder with
// configurable wait states, a monitor that records accepted instructions,
// and scenario tasks comparing them against a queue of expected words.
module tb_instr_fetch;

    typedef struct {
        logic [15:0] word;
        logic [15:0] pc;
        int          cyc;
    } xact_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic [15:0] instr_word;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        branch_en = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        halt = 1'b0;

    logic [7:0]  mem [0:65535];
    xact_t       exp_q[$];
    xact_t       obs_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          ack_cnt = 0;
    int          n_acc = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_ack(mem_ack), .mem_data(mem_data), .instr_word(instr_word),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_en(branch_en), .branch_target(branch_target), .halt(halt)
    );

    // Cycle counter used to time accepted instructions.
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: acks after ack_delay cycles of continuous request.
    always @(negedge clk) begin
        if (mem_rd === 1'b1) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack  <= 1'b1;
                mem_data <= mem[mem_addr];
                wait_cnt <= 0;
                ack_cnt  <= ack_cnt + 1;
            end else begin
                mem_ack  <= 1'b0;
                mem_data <= 8'h00;
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            mem_ack  <= 1'b0;
            mem_data <= 8'h00;
            wait_cnt <= 0;
        end
    end

    // Monitor: record every completed handshake.
    always @(negedge clk) begin
        if (reset === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            obs_q.push_back(xact_t'{instr_word, instr_pc, cyc});
            n_acc <= n_acc + 1;
        end
    end

    task automatic do_reset;
        reset = 1'b1;
        branch_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic wait_accepts(input int n, input int budget, output bit timed_out);
        int target;
        target = n_acc + n;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (n_acc >= target) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_hi_byte(output bit found);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (mem_rd === 1'b1 && mem_addr === 16'h0001) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic restore_mem;
        mem[16'h0000] = 8'h1C;
        mem[16'h0001] = 8'hA5;
        mem[16'h0002] = 8'h3E;
        mem[16'h0003] = 8'h07;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (instr_word !== 16'h0000) begin failures++; $display("FAIL reset_word: got %h want 0000", instr_word); end
        checks++; if (instr_pc !== 16'h0000) begin failures++; $display("FAIL reset_pc: got %h want 0000", instr_pc); end
        checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
        checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_basic;
        bit    to;
        xact_t o, e;
        int    c [2];
        instr_ready = 1'b1; halt = 1'b0; ack_delay = 0;
        do_reset();
        exp_q.push_back(xact_t'{16'hA51C, 16'h0000, 0});
        exp_q.push_back(xact_t'{16'h073E, 16'h0002, 0});
        wait_accepts(2, 60, to);
        instr_ready = 1'b0;
        checks++; if (to) begin failures++; $display("FAIL basic_timeout: got fewer than 2 accepts want 2"); end
        for (int k = 0; k < 2; k++) begin
            c[k] = 0;
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL basic_word%0d: got no word want one", k);
            end else begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); c[k] = o.cyc;
                if (o.word !== e.word || o.pc !== e.pc) begin
                    failures++; $display("FAIL basic_word%0d: got %h@%h want %h@%h", k, o.word, o.pc, e.word, e.pc);
                end
            end
        end
        checks++; if (c[1] - c[0] !== 3) begin failures++; $display("FAIL basic_rate: got %0d cycles want 3", c[1] - c[0]); end
    endtask

    task automatic test_stall;
        bit    to, found;
        int    base;
        xact_t o, e;
        instr_ready = 1'b0; halt = 1'b0; ack_delay = 0;
        do_reset();
        exp_q.push_back(xact_t'{16'hA51C, 16'h0000, 0});
        exp_q.push_back(xact_t'{16'h073E, 16'h0002, 0});
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (instr_valid === 1'b1) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin failures++; $display("FAIL stall_valid_timeout: got no valid want valid"); end
        base = ack_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (instr_valid !== 1'b1 || instr_word !== 16'hA51C || instr_pc !== 16'h0000 || mem_rd !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d: got v=%b %h@%h rd=%b want v=1 a51c@0000 rd=0", i, instr_valid, instr_word, instr_pc, mem_rd);
            end
        end
        checks++; if (ack_cnt !== base) begin failures++; $display("FAIL stall_reads: got %0d extra reads want 0", ack_cnt - base); end
        instr_ready = 1'b1;
        wait_accepts(2, 40, to);
        instr_ready = 1'b0;
        checks++; if (to) begin failures++; $display("FAIL stall_timeout: got fewer than 2 accepts want 2"); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL stall_word%0d: got no word want one", k);
            end else begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                if (o.word !== e.word || o.pc !== e.pc) begin
                    failures++; $display("FAIL stall_word%0d: got %h@%h want %h@%h", k, o.word, o.pc, e.word, e.pc);
                end
            end
        end
    endtask

    task automatic test_wait_states;
        bit    to;
        xact_t o, e;
        int    c [2];
        instr_ready = 1'b1; halt = 1'b0; ack_delay = 2;
        do_reset();
        exp_q.push_back(xact_t'{16'hA51C, 16'h0000, 0});
        exp_q.push_back(xact_t'{16'h073E, 16'h0002, 0});
        wait_accepts(2, 80, to);
        instr_ready = 1'b0;
        ack_delay = 0;
        checks++; if (to) begin failures++; $display("FAIL wait_timeout: got fewer than 2 accepts want 2"); end
        for (int k = 0; k < 2; k++) begin
            c[k] = 0;
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL wait_word%0d: got no word want one", k);
            end else begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); c[k] = o.cyc;
                if (o.word !== e.word || o.pc !== e.pc) begin
                    failures++; $display("FAIL wait_word%0d: got %h@%h want %h@%h", k, o.word, o.pc, e.word, e.pc);
                end
            end
        end
        checks++; if (c[1] - c[0] !== 7) begin failures++; $display("FAIL wait_rate: got %0d cycles want 7", c[1] - c[0]); end
    endtask

    task automatic test_branch_hi;
        bit    to, found;
        xact_t o;
        mem[16'h0100] = 8'h5A;
        mem[16'h0101] = 8'hC3;
        instr_ready = 1'b1; halt = 1'b0; ack_delay = 0;
        do_reset();
        exp_q.push_back(xact_t'{16'hC35A, 16'h0100, 0});
        wait_hi_byte(found);
        checks++; if (!found) begin failures++; $display("FAIL branch_hi_reach: got no high-byte read want one"); end
        branch_en = 1'b1; branch_target = 16'h0100;
        @(posedge clk); #1;
        branch_en = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL branch_valid: got %b want 0", instr_valid); end
        checks++; if (mem_addr !== 16'h0100) begin failures++; $display("FAIL branch_addr: got %h want 0100", mem_addr); end
        wait_accepts(1, 40, to);
        instr_ready = 1'b0;
        checks++;
        if (to || obs_q.size() == 0) begin
            failures++; $display("FAIL branch_word: got no word want c35a@0100");
        end else begin
            o = obs_q.pop_front();
            if (o.word !== exp_q[0].word || o.pc !== exp_q[0].pc) begin
                failures++; $display("FAIL branch_word: got %h@%h want %h@%h", o.word, o.pc, exp_q[0].word, exp_q[0].pc);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_wrap;
        bit    to;
        xact_t o, e;
        mem[16'hFFFF] = 8'h34;
        mem[16'h0000] = 8'h12;
        mem[16'h0001] = 8'h78;
        mem[16'h0002] = 8'h56;
        instr_ready = 1'b1; halt = 1'b1; ack_delay = 0;
        do_reset();
        branch_en = 1'b1; branch_target = 16'hFFFF;
        @(posedge clk); #1;
        branch_en = 1'b0;
        checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL wrap_halt_rd: got %b want 0", mem_rd); end
        checks++; if (mem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_halt_addr: got %h want ffff", mem_addr); end
        exp_q.push_back(xact_t'{16'h1234, 16'hFFFF, 0});
        exp_q.push_back(xact_t'{16'h5678, 16'h0001, 0});
        halt = 1'b0;
        wait_accepts(2, 40, to);
        instr_ready = 1'b0;
        checks++; if (to) begin failures++; $display("FAIL wrap_timeout: got fewer than 2 accepts want 2"); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL wrap_word%0d: got no word want one", k);
            end else begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                if (o.word !== e.word || o.pc !== e.pc) begin
                    failures++; $display("FAIL wrap_word%0d: got %h@%h want %h@%h", k, o.word, o.pc, e.word, e.pc);
                end
            end
        end
        restore_mem();
    endtask

    task automatic test_halt;
        bit    to;
        int    base;
        xact_t o;
        instr_ready = 1'b1; halt = 1'b1; ack_delay = 0;
        do_reset();
        base = ack_cnt;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (mem_rd !== 1'b0 || mem_addr !== 16'h0000) begin
                failures++; $display("FAIL halt_cycle%0d: got rd=%b addr=%h want rd=0 addr=0000", i, mem_rd, mem_addr);
            end
        end
        checks++; if (ack_cnt !== base) begin failures++; $display("FAIL halt_reads: got %0d reads want 0", ack_cnt - base); end
        halt = 1'b0;
        wait_accepts(1, 40, to);
        instr_ready = 1'b0;
        checks++;
        if (to || obs_q.size() == 0) begin
            failures++; $display("FAIL halt_resume: got no word want a51c@0000");
        end else begin
            o = obs_q.pop_front();
            if (o.word !== 16'hA51C || o.pc !== 16'h0000) begin
                failures++; $display("FAIL halt_resume: got %h@%h want a51c@0000", o.word, o.pc);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit    to, found;
        xact_t o;
        instr_ready = 1'b1; halt = 1'b0; ack_delay = 0;
        do_reset();
        wait_hi_byte(found);
        checks++; if (!found) begin failures++; $display("FAIL rstmid_reach: got no high-byte read want one"); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b want 0", instr_valid); end
        checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL rstmid_addr: got %h want 0000", mem_addr); end
        checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL rstmid_rd: got %b want 0", mem_rd); end
        reset = 1'b0;
        obs_q.delete();
        wait_accepts(1, 40, to);
        instr_ready = 1'b0;
        checks++;
        if (to || obs_q.size() == 0) begin
            failures++; $display("FAIL rstmid_word: got no word want a51c@0000");
        end else begin
            o = obs_q.pop_front();
            if (o.word !== 16'hA51C || o.pc !== 16'h0000) begin
                failures++; $display("FAIL rstmid_word: got %h@%h want a51c@0000", o.word, o.pc);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a] = a[7:0] ^ a[15:8] ^ 8'h5A;
        end
        restore_mem();
        test_reset();
        test_basic();
        test_stall();
        test_wait_states();
        test_branch_hi();
        test_wrap();
        test_halt();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Reads 16-bit instruction words as two consecutive bytes over the CPU's 8-bit memory read bus, low byte first.
- Assembles each word and presents it, with its address, to the decode/execute path through a valid/ready handshake.
- Owns the program counter and accepts redirects (jumps, relative jumps, calls, returns) as absolute targets computed downstream.

Parameters:
- RESET_PC, 16'h0000, address of the first instruction fetched after reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- mem_addr  output  16  byte address of the current read request
- mem_rd  output  1  read request; mem_addr is valid while high
- mem_ack  input  1  read completes this cycle; mem_data is valid
- mem_data  input  8  read data, sampled when mem_rd && mem_ack
- instr_word  output  16  assembled instruction word {high byte, low byte}
- instr_pc  output  16  address of the low byte of instr_word
- instr_valid  output  1  instr_word/instr_pc hold a fetched instruction
- instr_ready  input  1  consumer accepts the instruction this cycle
- branch_en  input  1  redirect request, single-cycle pulse
- branch_target  input  16  new fetch address, sampled when branch_en=1
- halt  input  1  suppresses new fetches while high

Behaviour:
- Reset is synchronous and active-high on clk. While reset=1:
  - pc<=RESET_PC, state<=FETCH_LO.
  - Outputs next cycle: mem_rd=0, instr_valid=0, instr_word=0, instr_pc=RESET_PC.
  - Reset mid-fetch discards any partial byte.
- States:
  - FETCH_LO
    - mem_rd=!halt, mem_addr=pc.
    - On mem_ack: lo<=mem_data, start_pc<=pc, pc<=pc+1, go to FETCH_HI.
  - FETCH_HI
    - mem_rd=1, mem_addr=pc. halt is ignored in this state.
    - On mem_ack: instr_word<={mem_data,lo}, instr_pc<=start_pc, pc<=pc+1, go to VALID.
  - VALID
    - instr_valid=1, mem_rd=0.
    - On instr_ready, go to FETCH_LO.
    - instr_word/instr_pc stay stable until accepted or flushed.
- Memory protocol:
  - Requests are combinational in the state; mem_ack may arrive in the same cycle as mem_rd.
  - Dropping mem_rd without an ack is legal; there are no outstanding transactions.
- Throughput: zero-wait memory gives one instruction per 3 cycles. Each wait cycle on mem_ack adds one cycle.
- pc arithmetic is modulo 2^16: 16'hFFFF+1 = 16'h0000. A word whose low byte sits at 16'hFFFF takes its high byte from 16'h0000. Odd addresses are legal.
- Redirect (branch_en=1) takes priority over everything except reset, in every state:
  - pc<=branch_target, state<=FETCH_LO, instr_valid=0 next cycle.
  - Any byte acked in the same cycle is discarded.
  - If branch_en coincides with instr_valid&&instr_ready, the handshake completes and the redirect still applies.
  - branch_en together with reset: reset wins.
- halt:
  - Checked only in FETCH_LO; holds mem_rd=0 and pc unchanged.
  - A word already in FETCH_HI completes. A word in VALID is still offered.
  - branch_en during halt updates pc; fetching resumes at the target when halt falls.
- instr_valid is never combinationally dependent on instr_ready.

Test Plan:
- Reset, RESET_PC=0, memory bytes 00:1C 01:A5 02:3E 03:07, zero-wait ack, instr_ready=1 → instr_word=16'hA51C pc=0, then 16'h073E pc=2; instr_valid high one cycle in each three.
- Same memory, instr_ready=0 for 5 cycles once 16'hA51C is valid → word and pc held stable, mem_rd=0, no extra reads, next word fetched after acceptance.
- mem_ack delayed 2 cycles per byte → each word appears 7 cycles after the previous fetch start, correct contents.
- branch_en with target 16'h0100 pulsed during FETCH_HI, with mem_ack the same cycle → byte discarded, instr_valid stays 0, next instruction has instr_pc=16'h0100 and contents from 0100/0101.
- Branch to 16'hFFFF, mem[FFFF]=34, mem[0000]=12 → instr_word=16'h1234, instr_pc=16'hFFFF; the following fetch starts at 16'h0001.
- halt raised in FETCH_LO for 4 cycles → mem_rd=0 throughout, pc unchanged. Reset asserted during FETCH_HI → next cycle instr_valid=0, mem_addr=RESET_PC.
